instr_encoder: RTL

//  Inverse of the main decoder: packs instruction descriptors (type, regs, funct, imm) into
//  32-bit RV32I words (lw-style I, S, R) and writes them sequentially into instruction memory.

---
 rtl/instr_encoder_pkg.sv | 22 ++
 rtl/instr_field_pack.sv | 27 ++
 rtl/instr_encoder.sv | 110 +++++++++++
 3 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared RV32I encoding types and opcode constants for the instruction encoder.
package pa_riscv;

    typedef enum logic [1:0] {
        INSTR_I = 2'd0,
        INSTR_S = 2'd1,
        INSTR_R = 2'd2
    } ty_instrType;

    typedef logic [31:0] ty_instrWord;

    localparam logic [6:0] OPC_I = 7'b0000011;  // load (lw-style)
    localparam logic [6:0] OPC_S = 7'b0100011;  // store
    localparam logic [6:0] OPC_R = 7'b0110011;  // register-register ALU

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DONE
    } ty_encState;

endpackage

// File: rtl/instr_field_pack.sv
// Pure combinational packer: instruction descriptor -> 32-bit RV32I word.
module instr_field_pack
    import pa_riscv::*;
(
    input  logic [1:0]  instr_type,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic        funct7bit5,
    input  logic [11:0] imm,
    output logic [31:0] word,
    output logic        legal
);

    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (ty_instrType'(instr_type))
            INSTR_I: word = {imm, rs1, funct3, rd, OPC_I};
            INSTR_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_S};
            INSTR_R: word = {1'b0, funct7bit5, 5'b0, rs2, rs1, funct3, rd, OPC_R};
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Sequential imem program loader: accepts descriptors, packs and writes them at +4 byte steps.
// Optional XOR checksum output enabled by INSTR_ENCODER_CHECKSUM_EN.
module instr_encoder
    import pa_riscv::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_arst_n,
    input  logic              i_start,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [1:0]        i_type,
    input  logic [4:0]        i_rd,
    input  logic [4:0]        i_rs1,
    input  logic [4:0]        i_rs2,
    input  logic [2:0]        i_funct3,
    input  logic              i_funct7bit5,
    input  logic [11:0]       i_imm,
    output logic              o_imemWrite,
    output logic [ADDR_W-1:0] o_imemAddr,
    output logic [31:0]       o_imemWriteData,
    output logic              o_done,
    output logic              o_error
`ifdef INSTR_ENCODER_CHECKSUM_EN
    ,
    output logic [31:0]       o_checksum
`endif
);

    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    ty_encState        state;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       word;
    logic              legal;
    logic              last;

    instr_field_pack u_pack (
        .instr_type (i_type),
        .rd         (i_rd),
        .rs1        (i_rs1),
        .rs2        (i_rs2),
        .funct3     (i_funct3),
        .funct7bit5 (i_funct7bit5),
        .imm        (i_imm),
        .word       (word),
        .legal      (legal)
    );

    assign o_ready = (state == ST_ACTIVE);
    assign last    = (count == CNT_W'(DEPTH - 1));

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state           <= ST_IDLE;
            count           <= '0;
            addr            <= '0;
            o_imemWrite     <= 1'b0;
            o_imemAddr      <= '0;
            o_imemWriteData <= '0;
            o_done          <= 1'b0;
            o_error         <= 1'b0;
`ifdef INSTR_ENCODER_CHECKSUM_EN
            o_checksum      <= '0;
`endif
        end else begin
            o_imemWrite <= 1'b0;
            case (state)
                ST_ACTIVE: begin
                    if (i_valid) begin
                        count <= count + CNT_W'(1);
                        // Illegal descriptors consume a slot but leave the address in place.
                        if (legal) begin
                            o_imemWrite     <= 1'b1;
                            o_imemAddr      <= addr;
                            o_imemWriteData <= word;
                            addr            <= addr + ADDR_W'(4);
`ifdef INSTR_ENCODER_CHECKSUM_EN
                            o_checksum      <= o_checksum ^ word;
`endif
                        end else begin
                            o_error <= 1'b1;
                        end
                        if (last) begin
                            state  <= ST_DONE;
                            o_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    // IDLE and DONE both restart a fresh load on i_start.
                    if (i_start) begin
                        state   <= ST_ACTIVE;
                        count   <= '0;
                        addr    <= '0;
                        o_done  <= 1'b0;
                        o_error <= 1'b0;
`ifdef INSTR_ENCODER_CHECKSUM_EN
                        o_checksum <= '0;
`endif
                    end
                end
            endcase
        end
    end

endmodule
